// File: rtl/st_width_upsizer.sv
// st_width_upsizer: packs RATIO narrow symbols per channel into one wide Avalon-ST beat
module st_width_upsizer #(
    parameter int SYMBOL_W  = 8,
    parameter int RATIO     = 4,
    parameter int CHANNELS  = 2,
    parameter int CHANNEL_W = 1,
    parameter int EMPTY_W   = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        in_ready,
    input  logic                        in_valid,
    input  logic [SYMBOL_W-1:0]         in_data,
    input  logic [CHANNEL_W-1:0]        in_channel,
    input  logic                        in_startofpacket,
    input  logic                        in_endofpacket,
    input  logic                        in_error,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [SYMBOL_W*RATIO-1:0]   out_data,
    output logic [CHANNEL_W-1:0]        out_channel,
    output logic                        out_startofpacket,
    output logic                        out_endofpacket,
    output logic [EMPTY_W-1:0]          out_empty,
    output logic                        out_error,
    output logic                        drop_pulse,
    output logic                        proto_err_pulse
);
    // state is sized for every encodable channel so indexing by in_channel never leaves the array
    localparam int NCH = 2 ** CHANNEL_W;

    logic [EMPTY_W-1:0]        r_count [NCH];
    logic [SYMBOL_W-1:0]       r_part  [NCH][RATIO];
    logic                      r_sop   [NCH];
    logic                      r_err   [NCH];
    logic                      r_pkt   [NCH];
    logic                      r_valid;
    logic [SYMBOL_W*RATIO-1:0] r_data;
    logic [CHANNEL_W-1:0]      r_channel;
    logic                      r_sop_o;
    logic                      r_eop_o;
    logic [EMPTY_W-1:0]        r_empty;
    logic                      r_err_o;
    logic                      r_drop;
    logic                      r_proto;

    logic                      w_acc;
    logic                      w_ch_ok;
    logic                      w_live;
    logic                      w_take;
    logic                      w_proto;
    logic [EMPTY_W-1:0]        w_k;
    logic                      w_sop;
    logic                      w_err;
    logic                      w_emit;
    logic [EMPTY_W-1:0]        w_empty;
    logic [SYMBOL_W*RATIO-1:0] w_word;

    assign in_ready          = out_ready | ~r_valid;
    assign out_valid         = r_valid;
    assign out_data          = r_data;
    assign out_channel       = r_channel;
    assign out_startofpacket = r_sop_o;
    assign out_endofpacket   = r_eop_o;
    assign out_empty         = r_empty;
    assign out_error         = r_err_o;
    assign drop_pulse        = r_drop;
    assign proto_err_pulse   = r_proto;

    // decode the beat: an SOP restarts the channel's word at lane 0, discarding any partial
    always_comb begin
        w_acc   = in_valid & in_ready;
        w_ch_ok = int'(in_channel) < CHANNELS;
        w_live  = w_ch_ok & (in_startofpacket | r_pkt[in_channel]);
        w_take  = w_acc & w_live;
        w_proto = w_acc & w_ch_ok & in_startofpacket & r_pkt[in_channel];
        w_k     = in_startofpacket ? '0 : r_count[in_channel];
        w_sop   = in_startofpacket | r_sop[in_channel];
        w_err   = in_error | (~in_startofpacket & r_err[in_channel]);
        w_emit  = in_endofpacket | (w_k == EMPTY_W'(RATIO - 1));
        w_empty = in_endofpacket ? EMPTY_W'(RATIO - 1) - w_k : '0;
        w_word  = '0;
        for (int i = 0; i < RATIO; i++)
            w_word[(RATIO-i)*SYMBOL_W-1 -: SYMBOL_W] = (i < int'(w_k)) ? r_part[in_channel][i] :
                                                       (i == int'(w_k)) ? in_data : '0;
    end

    // per-channel partial word, flags and packet tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                r_count[c] <= '0;
                r_sop[c]   <= 1'b0;
                r_err[c]   <= 1'b0;
                r_pkt[c]   <= 1'b0;
                for (int i = 0; i < RATIO; i++)
                    r_part[c][i] <= '0;
            end
        end else if (w_take) begin
            r_pkt[in_channel]        <= ~in_endofpacket;
            r_count[in_channel]      <= w_emit ? '0 : w_k + 1'b1;
            r_sop[in_channel]        <= ~w_emit & w_sop;
            r_err[in_channel]        <= ~w_emit & w_err;
            r_part[in_channel][w_k]  <= in_data;
        end
    end

    // output register advances only when the downstream can take a word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_channel <= '0;
            r_sop_o   <= 1'b0;
            r_eop_o   <= 1'b0;
            r_empty   <= '0;
            r_err_o   <= 1'b0;
        end else if (in_ready) begin
            r_valid <= w_take & w_emit;
            if (w_take & w_emit) begin
                r_data    <= w_word;
                r_channel <= in_channel;
                r_sop_o   <= w_sop;
                r_eop_o   <= in_endofpacket;
                r_empty   <= w_empty;
                r_err_o   <= w_err;
            end
        end
    end

    // single-cycle event pulses for discarded beats and restarted packets
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop  <= 1'b0;
            r_proto <= 1'b0;
        end else begin
            r_drop  <= w_acc & ~w_live;
            r_proto <= w_proto;
        end
    end
endmodule

// File: tb/tb_st_width_upsizer.sv
// tb_st_width_upsizer: directed and random stimulus against a queue-based packing model
module tb_st_width_upsizer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_ready;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic [1:0]  in_channel = '0;
    logic        in_startofpacket = 1'b0;
    logic        in_endofpacket = 1'b0;
    logic        in_error = 1'b0;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_channel;
    logic        out_startofpacket;
    logic        out_endofpacket;
    logic [1:0]  out_empty;
    logic        out_error;
    logic        drop_pulse;
    logic        proto_err_pulse;

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0]  m_syms [2][$];
    bit          m_sop [2];
    bit          m_err [2];
    bit          m_pkt [2];
    bit          e_valid;
    logic [31:0] e_data;
    logic [1:0]  e_ch;
    bit          e_sop, e_eop, e_err;
    logic [1:0]  e_empty;

    st_width_upsizer #(.SYMBOL_W(8), .RATIO(4), .CHANNELS(2), .CHANNEL_W(2), .EMPTY_W(2)) dut (
        .clk(clk), .reset(reset), .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
        .in_channel(in_channel), .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
        .in_error(in_error), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_channel(out_channel), .out_startofpacket(out_startofpacket),
        .out_endofpacket(out_endofpacket), .out_empty(out_empty), .out_error(out_error),
        .drop_pulse(drop_pulse), .proto_err_pulse(proto_err_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] pack(input logic [7:0] q[$]);
        logic [31:0] w = '0;
        foreach (q[i]) w[31-8*i -: 8] = q[i];
        return w;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin
            m_syms[c].delete();
            m_sop[c] = 0;
            m_err[c] = 0;
            m_pkt[c] = 0;
        end
        e_valid = 0; e_data = '0; e_ch = '0; e_sop = 0; e_eop = 0; e_err = 0; e_empty = '0;
    endtask

    task automatic beat(input bit v, input int ch, input logic [7:0] d, input bit s, input bit e,
                        input bit er, input bit ordy);
        bit rdy, emit, drop, proto;
        logic [1:0] chb;
        chb = ch[1:0];
        in_valid = v; in_channel = chb; in_data = d;
        in_startofpacket = s; in_endofpacket = e; in_error = er; out_ready = ordy;
        #1;
        rdy = ordy || !e_valid;
        chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
        emit = 0; drop = 0; proto = 0;
        if (v && rdy) begin
            if (ch >= 2) drop = 1;
            else if (!s && !m_pkt[ch]) drop = 1;
            else begin
                if (s) begin
                    proto = m_pkt[ch];
                    m_syms[ch].delete();
                    m_sop[ch] = 1;
                    m_err[ch] = 0;
                    m_pkt[ch] = 1;
                end
                m_syms[ch].push_back(d);
                m_err[ch] |= er;
                if (m_syms[ch].size() == 4 || e) begin
                    emit    = 1;
                    e_data  = pack(m_syms[ch]);
                    e_ch    = chb;
                    e_sop   = m_sop[ch];
                    e_eop   = e;
                    e_empty = e ? 2'(4 - m_syms[ch].size()) : 2'd0;
                    e_err   = m_err[ch];
                    m_syms[ch].delete();
                    m_sop[ch] = 0;
                    m_err[ch] = 0;
                end
                if (e) m_pkt[ch] = 0;
            end
        end
        if (rdy) e_valid = emit;
        @(posedge clk);
        #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, e_valid});
        if (e_valid) begin
            chk("out_data", out_data, e_data);
            chk("out_channel", {30'b0, out_channel}, {30'b0, e_ch});
            chk("out_sop", {31'b0, out_startofpacket}, {31'b0, e_sop});
            chk("out_eop", {31'b0, out_endofpacket}, {31'b0, e_eop});
            chk("out_empty", {30'b0, out_empty}, {30'b0, e_empty});
            chk("out_error", {31'b0, out_error}, {31'b0, e_err});
        end
        chk("drop_pulse", {31'b0, drop_pulse}, {31'b0, drop});
        chk("proto_pulse", {31'b0, proto_err_pulse}, {31'b0, proto});
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_flags", {24'b0, out_channel, out_startofpacket, out_endofpacket, out_empty, out_error,
                          drop_pulse}, 32'd0);
        chk("rst_proto", {31'b0, proto_err_pulse}, 32'd0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        model_clear();
        do_reset();
        beat(1, 0, 8'h11, 1, 0, 0, 1);
        beat(1, 0, 8'h22, 0, 0, 0, 1);
        beat(1, 0, 8'h33, 0, 0, 0, 1);
        beat(1, 0, 8'h44, 0, 1, 0, 1);
        chk("t1_data", out_data, 32'h11223344);
        chk("t1_sop_eop_empty", {28'b0, out_startofpacket, out_endofpacket, out_empty}, 32'hc);
        beat(1, 0, 8'hAA, 1, 0, 0, 1);
        beat(1, 0, 8'hBB, 0, 0, 0, 1);
        beat(1, 0, 8'hCC, 0, 0, 0, 1);
        beat(1, 0, 8'hDD, 0, 0, 0, 1);
        chk("t2_word0", out_data, 32'hAABBCCDD);
        chk("t2_word0_flags", {28'b0, out_startofpacket, out_endofpacket, out_empty}, 32'h8);
        beat(1, 0, 8'hEE, 0, 1, 0, 1);
        chk("t2_word1", out_data, 32'hEE000000);
        chk("t2_word1_flags", {28'b0, out_startofpacket, out_endofpacket, out_empty}, 32'h7);
        beat(1, 0, 8'h01, 1, 0, 0, 1);
        beat(1, 1, 8'hA1, 1, 0, 0, 1);
        beat(1, 0, 8'h02, 0, 0, 0, 1);
        beat(1, 1, 8'hA2, 0, 0, 0, 1);
        beat(1, 0, 8'h03, 0, 0, 0, 1);
        beat(1, 1, 8'hA3, 0, 0, 0, 1);
        beat(1, 0, 8'h04, 0, 1, 0, 1);
        chk("t3_ch0", out_data, 32'h01020304);
        beat(1, 1, 8'hA4, 0, 1, 0, 1);
        chk("t3_ch1", out_data, 32'hA1A2A3A4);
        chk("t3_ch1_chan", {30'b0, out_channel}, 32'd1);
        beat(1, 0, 8'h10, 1, 0, 0, 1);
        beat(1, 0, 8'h20, 0, 0, 0, 1);
        beat(1, 0, 8'h30, 0, 0, 0, 1);
        beat(1, 0, 8'h40, 0, 1, 0, 1);
        for (int i = 0; i < 5; i++) beat(1, 0, 8'h50, 1, 0, 0, 0);
        chk("t4_hold", out_data, 32'h10203040);
        chk("t4_stalled_ready", {31'b0, in_ready}, 32'd0);
        beat(1, 0, 8'h50, 1, 0, 0, 1);
        beat(1, 0, 8'h60, 0, 0, 0, 1);
        beat(1, 0, 8'h70, 0, 0, 0, 1);
        beat(1, 0, 8'h80, 0, 1, 0, 1);
        chk("t4_resume", out_data, 32'h50607080);
        beat(1, 0, 8'h11, 1, 0, 0, 1);
        beat(1, 0, 8'h22, 0, 0, 0, 1);
        beat(1, 0, 8'h55, 1, 0, 0, 1);
        chk("t5_proto", {31'b0, proto_err_pulse}, 32'd1);
        beat(1, 0, 8'h66, 0, 0, 1, 1);
        chk("t5_proto_once", {31'b0, proto_err_pulse}, 32'd0);
        beat(1, 0, 8'h77, 0, 0, 0, 1);
        beat(1, 0, 8'h88, 0, 1, 0, 1);
        chk("t5_data", out_data, 32'h55667788);
        chk("t5_error", {31'b0, out_error}, 32'd1);
        beat(1, 3, 8'h99, 1, 0, 0, 1);
        chk("t6_drop", {31'b0, drop_pulse}, 32'd1);
        chk("t6_no_out", {31'b0, out_valid}, 32'd0);
        beat(0, 0, 8'h00, 0, 0, 0, 1);
        chk("t6_drop_once", {31'b0, drop_pulse}, 32'd0);
        beat(1, 0, 8'h11, 1, 0, 0, 1);
        beat(1, 0, 8'h22, 0, 0, 0, 1);
        do_reset();
        beat(1, 0, 8'h9A, 1, 0, 0, 1);
        beat(1, 0, 8'hBC, 0, 0, 0, 1);
        beat(1, 0, 8'hDE, 0, 0, 0, 1);
        beat(1, 0, 8'hF0, 0, 1, 0, 1);
        chk("t7_after_reset", out_data, 32'h9ABCDEF0);
        beat(1, 1, 8'h77, 1, 1, 0, 1);
        chk("t8_single", out_data, 32'h77000000);
        chk("t8_empty", {30'b0, out_empty}, 32'd3);
        for (int i = 0; i < 3000; i++)
            beat($urandom_range(0, 9) < 8,
                 ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)),
                 $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
        for (int i = 0; i < 3; i++) beat(0, 0, 8'h00, 0, 0, 0, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
